// File: rtl/fp32_div_arbiter.sv
// Round-robin arbiter that time-shares one combinational fp32 divider, holding operands as a multicycle path.
// Optional sticky exception accumulator enabled by defining FP32_DIV_ARB_FFLAGS_EN.
module fp32_div_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int DIV_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    output logic [31:0]             div_a,
    output logic [31:0]             div_b,
    input  logic [31:0]             div_y,
    input  logic [4:0]              div_exc,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [31:0]             resp_y,
    output logic [4:0]              resp_flags,
    output logic                    busy
`ifdef FP32_DIV_ARB_FFLAGS_EN
    ,
    input  logic                    fflags_clr,
    output logic [4:0]              fflags
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Valid never waits on ready; once resp_valid rises, the payload is held until the transfer.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   txn_id;
    logic [ID_W-1:0]   rr_ptr_nxt;
    logic              grant_vld;
    logic [ID_W:0]     scan_idx;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;
    logic              accept;
    logic              exec_done;
    logic              resp_hs;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_vld && req_valid[scan_idx[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = scan_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_id) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
    end

    always_comb begin
        if (grant_id == ID_W'(NUM_REQ-1)) begin
            rr_ptr_nxt = '0;
        end else begin
            rr_ptr_nxt = grant_id + ID_W'(1);
        end
    end

    assign accept    = (state == IDLE) && grant_vld;
    assign exec_done = (state == EXEC) && (cnt == '0);
    assign resp_hs   = resp_valid && resp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = EXEC;
            EXEC:    if (exec_done) state_nxt = RESP;
            RESP:    if (resp_hs)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = (state != IDLE);
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Operands stay on div_a/div_b from accept until the next accept; the divider sees a static input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            txn_id     <= '0;
            cnt        <= '0;
            div_a      <= '0;
            div_b      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_y     <= '0;
            resp_flags <= '0;
        end else begin
            if (accept) begin
                div_a  <= sel_a;
                div_b  <= sel_b;
                txn_id <= grant_id;
                rr_ptr <= rr_ptr_nxt;
                cnt    <= CNT_W'(DIV_CYCLES-1);
            end
            if ((state == EXEC) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (exec_done) begin
                resp_y     <= div_y;
                resp_flags <= div_exc;
                resp_id    <= txn_id;
                resp_valid <= 1'b1;
            end else if (resp_hs) begin
                resp_valid <= 1'b0;
            end
        end
    end

`ifdef FP32_DIV_ARB_FFLAGS_EN
    // Clear takes effect before the OR so a coincident response survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fflags <= '0;
        end else if (resp_hs) begin
            fflags <= (fflags_clr ? 5'd0 : fflags) | resp_flags;
        end else if (fflags_clr) begin
            fflags <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_fp32_div_arbiter.sv
// Self-checking bench for fp32_div_arbiter: behavioural divider stand-in, round-robin model and response scoreboard.
// Exercises the fflags accumulator too when FP32_DIV_ARB_FFLAGS_EN is defined.
module tb_fp32_div_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int ID_W       = 2;
    localparam int DIV_CYCLES = 2;
    localparam int E_W        = ID_W + 37;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [31:0]           div_a;
    logic [31:0]           div_b;
    logic [31:0]           div_y;
    logic [4:0]            div_exc;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [31:0]           resp_y;
    logic [4:0]            resp_flags;
    logic                  busy;
    logic                  fflags_clr;
    logic [4:0]            fflags;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;
    logic [E_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    fp32_div_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .div_a(div_a), .div_b(div_b),
        .div_y(div_y), .div_exc(div_exc), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_y(resp_y), .resp_flags(resp_flags), .busy(busy)
`ifdef FP32_DIV_ARB_FFLAGS_EN
        , .fflags_clr(fflags_clr), .fflags(fflags)
`endif
    );

`ifndef FP32_DIV_ARB_FFLAGS_EN
    assign fflags = 5'd0;
`endif

    // Divider stand-in: exact answers for the named vectors, an arbitrary bijective scramble otherwise.
    function automatic logic [36:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return {32'h7FC00000, 5'h10};
        if (b[30:0] == 31'd0) return {a[31] ^ b[31], 31'h7F800000, 5'h08};
        if (a == 32'h3F800000 && b == 32'h40000000) return {32'h3F000000, 5'h00};
        if (a == 32'h3F800000 && b == 32'h40400000) return {32'h3EAAAAAB, 5'h01};
        return {a ^ {b[7:0], b[31:8]} ^ 32'h13579BDF, a[4:0] ^ b[9:5]};
    endfunction

    assign {div_y, div_exc} = ref_div(div_a, div_b);

    function automatic int model_grant(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (((int'(v) >> ((ptr + k) % NUM_REQ)) & 1) != 0) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
    endtask

    // One complete transaction from IDLE: grant, execute, optional backpressure, response handshake.
    task automatic run_txn(input int hold, input bit drop, input bit clr_at_hs,
                           output int g, output logic [E_W-1:0] obs);
        logic [E_W-1:0]     e;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [31:0]        a;
        logic [31:0]        b;
        int                 n;
        obs = '0;
        #1;
        g = model_grant(req_valid, model_ptr);
        exp_rdy = (g < 0) ? '0 : (NUM_REQ'(1) << g);
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL grant req_ready got %b exp %b", req_ready, exp_rdy);
        end
        if (g < 0) return;
        a = req_a[32*g +: 32];
        b = req_b[32*g +: 32];
        exp_q.push_back({ID_W'(g), ref_div(a, b)});
        model_ptr = (g + 1) % NUM_REQ;
        resp_ready = (hold == 0);
        tick();
        if (drop) req_valid = req_valid & ~(NUM_REQ'(1) << g);
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            checks++;
            if (busy !== 1'b1 || req_ready !== '0) begin
                errors++;
                $display("FAIL exec_ctrl busy %b req_ready %b exp busy 1 req_ready 0", busy, req_ready);
            end
            checks++;
            if (div_a !== a || div_b !== b) begin
                errors++;
                $display("FAIL exec_operands got %h/%h exp %h/%h", div_a, div_b, a, b);
            end
            tick();
            n++;
        end
        checks++;
        if (n !== DIV_CYCLES) begin
            errors++;
            $display("FAIL latency got %0d exp %0d", n, DIV_CYCLES);
        end
        e = exp_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            checks++;
            if ({resp_id, resp_y, resp_flags} !== e || resp_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_payload got %h v%b exp %h v1", {resp_id, resp_y, resp_flags}, resp_valid, e);
            end
            checks++;
            if (busy !== 1'b1 || req_ready !== '0) begin
                errors++;
                $display("FAIL hold_ctrl busy %b req_ready %b exp busy 1 req_ready 0", busy, req_ready);
            end
            tick();
        end
        checks++;
        if ({resp_id, resp_y, resp_flags} !== e) begin
            errors++;
            $display("FAIL resp_payload got %h exp %h", {resp_id, resp_y, resp_flags}, e);
        end
        obs = {resp_id, resp_y, resp_flags};
        fflags_clr = clr_at_hs;
        resp_ready = 1'b1;
        tick();
        fflags_clr = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL complete resp_valid %b busy %b exp 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b0;
        fflags_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({resp_valid, busy, req_ready, resp_id, resp_y, resp_flags, div_a, div_b, fflags} !== '0) begin
            errors++;
            $display("FAIL reset_state got v%b b%b r%b id%h y%h f%h a%h b%h ff%h exp all zero",
                     resp_valid, busy, req_ready, resp_id, resp_y, resp_flags, div_a, div_b, fflags);
        end
    endtask

    task automatic test_basic();
        int g;
        logic [E_W-1:0] obs;
        set_op(1, 32'h3F800000, 32'h40000000);
        req_valid = 4'b0010;
        run_txn(0, 1'b1, 1'b0, g, obs);
        checks++;
        if (obs !== {2'd1, 32'h3F000000, 5'h00}) begin
            errors++;
            $display("FAIL basic_divide got %h exp %h", obs, {2'd1, 32'h3F000000, 5'h00});
        end
    endtask

    task automatic test_exceptions();
        int g;
        logic [E_W-1:0] obs;
        set_op(2, 32'h3F800000, 32'h00000000);
        req_valid = 4'b0100;
        run_txn(0, 1'b1, 1'b0, g, obs);
        checks++;
        if (obs !== {2'd2, 32'h7F800000, 5'h08}) begin
            errors++;
            $display("FAIL div_by_zero got %h exp %h", obs, {2'd2, 32'h7F800000, 5'h08});
        end
        set_op(3, 32'h00000000, 32'h00000000);
        req_valid = 4'b1000;
        run_txn(0, 1'b1, 1'b0, g, obs);
        checks++;
        if (obs !== {2'd3, 32'h7FC00000, 5'h10}) begin
            errors++;
            $display("FAIL zero_by_zero got %h exp %h", obs, {2'd3, 32'h7FC00000, 5'h10});
        end
    endtask

    task automatic test_round_robin();
        int g;
        logic [E_W-1:0] obs;
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'h40000000 + i, 32'h3F000000 + 7 * i);
        req_valid = '1;
        for (int i = 0; i < 5; i++) begin
            run_txn(0, 1'b0, 1'b0, g, obs);
            checks++;
            if (g !== i % NUM_REQ || obs[E_W-1:37] !== ID_W'(i % NUM_REQ)) begin
                errors++;
                $display("FAIL rr_order step %0d got grant %0d id %0d exp %0d", i, g, obs[E_W-1:37], i % NUM_REQ);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int g;
        logic [E_W-1:0] obs;
        set_op(1, 32'h12345678, 32'h3F8ABCDE);
        set_op(2, 32'h0BADF00D, 32'h40490FDB);
        req_valid = 4'b0110;
        run_txn(5, 1'b1, 1'b0, g, obs);
        checks++;
        if (g !== model_grant(4'b0110, 1) || obs[E_W-1:37] !== ID_W'(g)) begin
            errors++;
            $display("FAIL bp_id got grant %0d id %0d exp 1", g, obs[E_W-1:37]);
        end
        run_txn(3, 1'b1, 1'b0, g, obs);
        req_valid = '0;
    endtask

    task automatic test_reset_mid_op();
        int g;
        logic [E_W-1:0] obs;
        set_op(2, 32'hC0A00000, 32'h40200000);
        req_valid = 4'b0100;
        resp_ready = 1'b1;
        tick();
        req_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({resp_valid, busy, req_ready, resp_id, resp_y, resp_flags, div_a, div_b} !== '0) begin
            errors++;
            $display("FAIL mid_reset_state got v%b b%b r%b a%h b%h exp all zero", resp_valid, busy, req_ready, div_a, div_b);
        end
        tick();
        rst = 1'b0;
        model_ptr = 0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (resp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_no_resp got v%b busy%b exp 0 0", resp_valid, busy);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'h3F800000 + (i << 4), 32'h40800000 + i);
        req_valid = '1;
        run_txn(0, 1'b0, 1'b0, g, obs);
        checks++;
        if (g !== 0) begin
            errors++;
            $display("FAIL post_reset_grant got %0d exp 0", g);
        end
        req_valid = '0;
    endtask

`ifdef FP32_DIV_ARB_FFLAGS_EN
    task automatic test_fflags();
        int g;
        logic [E_W-1:0] obs;
        set_op(0, 32'h00000000, 32'h00000000);
        req_valid = 4'b0001;
        run_txn(0, 1'b1, 1'b0, g, obs);
        checks++;
        if (fflags !== 5'h10) begin errors++; $display("FAIL fflags_nan got %h exp 10", fflags); end
        set_op(1, 32'h3F800000, 32'h40400000);
        req_valid = 4'b0010;
        run_txn(0, 1'b1, 1'b0, g, obs);
        checks++;
        if (obs[36:0] !== {32'h3EAAAAAB, 5'h01} || fflags !== 5'h11) begin
            errors++;
            $display("FAIL fflags_third got y %h ff %h exp 3eaaaaab01 ff 11", obs[36:0], fflags);
        end
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        checks++;
        if (fflags !== 5'h00) begin errors++; $display("FAIL fflags_clr got %h exp 00", fflags); end
        set_op(2, 32'h00000000, 32'h00000000);
        req_valid = 4'b0100;
        run_txn(0, 1'b1, 1'b0, g, obs);
        set_op(3, 32'h3F800000, 32'h00000000);
        req_valid = 4'b1000;
        run_txn(2, 1'b1, 1'b1, g, obs);
        checks++;
        if (fflags !== 5'h08) begin errors++; $display("FAIL fflags_clr_hs got %h exp 08", fflags); end
        req_valid = '0;
    endtask
`endif

    task automatic test_random();
        int g;
        logic [E_W-1:0] obs;
        for (int it = 0; it < 24; it++) begin
            req_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++) begin
                set_op(i, $urandom, ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom);
            end
            run_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, g, obs);
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exceptions();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
`ifdef FP32_DIV_ARB_FFLAGS_EN
        test_fflags();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
